timer_sequencer: RTL and testbench
==================================

# timer_sequencer

Control FSM for the four-digit mm:ss down-timer in the microwave front panel. Turns keypad digits into the timer's one-digit-per-cycle shift-load pulses, gates the timer's count enable with a prescaled one-cycle tick, and handles start/stop/door interlocks. Raises the heater enable while counting and a timed alarm when the timer reports zero. Sits between the keypad/panel logic and the timer datapath; the top level ORs `timer_clr` into the timer's reset.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per timer decrement; legal range ≥ 2.
- `ALARM_CYCLES`, default 150_000_000: alarm duration in cycles; legal range ≥ 1.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  BCD digit 0–9. Values 10–15 are ignored.
- `start`  in  1  one-cycle start/resume strobe.
- `stop`  in  1  one-cycle pause/cancel strobe.
- `door_closed`  in  1  level input; 1 means the door is closed.
- `timer_finished`  in  1  timer reports all four digits equal to 0.
- `timer_load`  out  1  one-cycle shift-load pulse to the timer.
- `timer_in`  out  4  digit presented with `timer_load`.
- `timer_enablen`  out  1  active-low count enable; low for exactly one cycle per tick.
- `timer_clr`  out  1  one-cycle clear pulse to the timer.
- `heater_on`  out  1  high only in RUN.
- `alarm`  out  1  high only in DONE.
- `state`  out  3  encoding: IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4, QLOAD=5.

## Operation
- Input priority when several strobes arrive in the same cycle: `stop` > door open > `start` > `key_valid`. Lower-priority events in that cycle are dropped.
- IDLE: a valid digit issues a load pulse, sets `digit_cnt`=1 and moves to ENTRY. `start` moves to RUN only if `door_closed` and `!timer_finished`; otherwise it is ignored (see Configuration).
- ENTRY:
  - Each valid digit issues a load pulse while `digit_cnt` < 4, then `digit_cnt` increments. A 5th or later digit is ignored.
  - `start` with `door_closed` and `!timer_finished` goes to RUN.
  - `stop` pulses `timer_clr`, clears `digit_cnt` and goes to IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. On terminal count, `timer_enablen`=0 for the next cycle.
  - `timer_finished`=1 goes to DONE.
  - `stop` or `!door_closed` goes to PAUSE with the prescaler value held.
  - Keys are ignored.
- PAUSE:
  - `start` with `door_closed` resumes RUN from the held prescaler value.
  - `stop` pulses `timer_clr`, clears the prescaler and `digit_cnt`, and goes to IDLE.
  - Keys are ignored.
- DONE:
  - `alarm` stays high until the alarm counter reaches ALARM_CYCLES-1, or until `stop`, `start` or `key_valid` acknowledges it.
  - On exit: go to IDLE, clear `digit_cnt` and the prescaler.
  - The acknowledging key is not loaded.
- Every event not listed above leaves state and counters unchanged.

## Timing
- Reset values:
  - `state`=IDLE.
  - `timer_load`=0, `timer_in`=0, `timer_enablen`=1, `timer_clr`=0.
  - `heater_on`=0, `alarm`=0.
  - Prescaler, alarm counter and `digit_cnt` all 0.
- All outputs are registered. Every response appears one cycle after the input is sampled.
- Load pulse: `timer_load` and `timer_in` are valid together for exactly 1 cycle. Back-to-back key strobes produce back-to-back pulses.
- First tick after entering RUN from ENTRY: `timer_enablen` goes low TICK_DIV cycles after the `state` change.
- `timer_enablen` is forced to 1 outside RUN, and in the cycle RUN exits.
- Finish: `timer_finished` sampled high in cycle N gives `state`=DONE and `alarm`=1 at N+1, with `heater_on` falling at N+1. TICK_DIV ≥ 2 guarantees no extra tick fires after zero is reached.
- Reset mid-operation: `rst` wins over every input and returns all values to reset values in the next cycle.

## Configuration
- `TIMER_SEQUENCER_QUICKSTART_EN`
  - Defined: `start` in IDLE with `door_closed` and `timer_finished`=1 enters QLOAD. QLOAD issues load 3 in cycle 1 and load 0 in cycle 2 (preset 00:30), then goes to RUN. `stop` or door open during QLOAD pulses `timer_clr` and returns to IDLE.
  - Undefined: QLOAD does not exist; that `start` is ignored.

## Test plan
- Reset, then keys 1,3,0,0 on consecutive cycles → four 1-cycle `timer_load` pulses carrying 1,3,0,0; `state`=ENTRY; a 5th key produces no pulse.
- TICK_DIV=4, preset 00:02, `start` → `timer_enablen` low at cycles 4 and 8 after RUN; `timer_finished` rises → `state`=DONE, `alarm`=1, `heater_on`=0 the following cycle.
- Door opens in RUN at prescaler=2, closes, then `start` → PAUSE, then RUN; next tick 2 cycles after resume; `heater_on` 0 during PAUSE.
- `stop` in PAUSE → one `timer_clr` pulse, `state`=IDLE; `stop`+`start`+key in the same RUN cycle → PAUSE only.
- ALARM_CYCLES=5 → `alarm` high exactly 5 cycles, then IDLE; key during DONE → IDLE next cycle, no load pulse.
- With QUICKSTART_EN, `start` in IDLE with `timer_finished`=1 → loads 3 then 0, then RUN; without it → `state` stays IDLE.

Source files
------------

// File: rtl/timer_sequencer_if.sv
// Panel-side handshake bundle for the microwave timer sequencer.
// master drives keypad/panel/timer status; slave is the sequencer.
interface timer_sequencer_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       timer_finished;
  logic       timer_load;
  logic [3:0] timer_in;
  logic       timer_enablen;
  logic       timer_clr;
  logic       heater_on;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output key_valid, key_digit, start, stop,
    output door_closed, timer_finished,
    input  timer_load, timer_in, timer_enablen,
    input  timer_clr, heater_on, alarm, state
  );

  modport slave (
    input  key_valid, key_digit, start, stop,
    input  door_closed, timer_finished,
    output timer_load, timer_in, timer_enablen,
    output timer_clr, heater_on, alarm, state
  );
endinterface

// File: rtl/timer_sequencer.sv
// mm:ss down-timer control FSM: digit loading, tick gating, interlocks, alarm.
// Optional TIMER_SEQUENCER_QUICKSTART_EN adds the 00:30 quick-start preset.
module timer_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ALARM_CYCLES = 150_000_000
) (
  input logic               clk,
  input logic               rst,
  timer_sequencer_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
    S_DONE  = 3'd4,
    S_QLOAD = 3'd5
`else
    S_DONE  = 3'd4
`endif
  } state_t;

  state_t          r_state, w_nstate;
  logic [2:0]      r_cnt, w_ncnt;
  logic [PW-1:0]   r_presc, w_npresc;
  logic [AW-1:0]   r_acnt, w_nacnt;
  logic            r_load, w_nload;
  logic [3:0]      r_in, w_nin;
  logic            r_enn, w_nenn;
  logic            r_clr, w_nclr;
  logic            r_heat, r_alarm;
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
  logic            r_qph, w_nqph;
`endif

  logic w_stop, w_start, w_key, w_tc, w_fin, w_ack, w_aend;

  // Priority: stop > door open > start > key
  always_comb begin
    w_stop  = bus.stop;
    w_start = bus.start && !bus.stop && bus.door_closed;
    w_key   = bus.key_valid && !bus.stop && bus.door_closed &&
              !bus.start && (bus.key_digit <= 4'd9);
    w_fin   = bus.timer_finished;
    w_tc    = (r_presc == PW'(TICK_DIV - 1));
    w_ack   = bus.stop || bus.start || bus.key_valid;
    w_aend  = (r_acnt == AW'(ALARM_CYCLES - 1));
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_npresc = r_presc;
    w_nacnt  = r_acnt;
    w_nload  = 1'b0;
    w_nin    = 4'd0;
    w_nenn   = 1'b1;
    w_nclr   = 1'b0;
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
    w_nqph   = r_qph;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_start && !w_fin) begin
          w_nstate = S_RUN;
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
        end else if (w_start && w_fin) begin
          w_nstate = S_QLOAD;
          w_nload  = 1'b1;
          w_nin    = 4'd3;
          w_nqph   = 1'b0;
`endif
        end else if (w_key) begin
          w_nstate = S_ENTRY;
          w_nload  = 1'b1;
          w_nin    = bus.key_digit;
          w_ncnt   = 3'd1;
        end
      end
      S_ENTRY: begin
        if (w_stop) begin
          w_nstate = S_IDLE;
          w_nclr   = 1'b1;
          w_ncnt   = 3'd0;
          w_npresc = '0;
        end else if (w_start) begin
          if (!w_fin) w_nstate = S_RUN;
        end else if (w_key && r_cnt < 3'd4) begin
          w_nload = 1'b1;
          w_nin   = bus.key_digit;
          w_ncnt  = r_cnt + 3'd1;
        end
      end
      S_RUN: begin
        if (w_stop || !bus.door_closed) begin
          w_nstate = S_PAUSE;
        end else if (w_fin) begin
          w_nstate = S_DONE;
        end else begin
          w_npresc = w_tc ? '0 : r_presc + 1'b1;
          w_nenn   = !w_tc;
        end
      end
      S_PAUSE: begin
        if (w_stop) begin
          w_nstate = S_IDLE;
          w_nclr   = 1'b1;
          w_ncnt   = 3'd0;
          w_npresc = '0;
        end else if (w_start) begin
          w_nstate = S_RUN;
        end
      end
      S_DONE: begin
        if (w_ack || w_aend) begin
          w_nstate = S_IDLE;
          w_ncnt   = 3'd0;
          w_npresc = '0;
          w_nacnt  = '0;
        end else begin
          w_nacnt = r_acnt + 1'b1;
        end
      end
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
      S_QLOAD: begin
        if (w_stop || !bus.door_closed) begin
          w_nstate = S_IDLE;
          w_nclr   = 1'b1;
          w_nqph   = 1'b0;
        end else if (!r_qph) begin
          w_nload = 1'b1;
          w_nin   = 4'd0;
          w_nqph  = 1'b1;
        end else begin
          w_nstate = S_RUN;
          w_nqph   = 1'b0;
        end
      end
`endif
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_presc <= '0;
      r_acnt  <= '0;
      r_load  <= 1'b0;
      r_in    <= 4'd0;
      r_enn   <= 1'b1;
      r_clr   <= 1'b0;
      r_heat  <= 1'b0;
      r_alarm <= 1'b0;
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
      r_qph   <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_presc <= w_npresc;
      r_acnt  <= w_nacnt;
      r_load  <= w_nload;
      r_in    <= w_nin;
      r_enn   <= w_nenn;
      r_clr   <= w_nclr;
      r_heat  <= (w_nstate == S_RUN);
      r_alarm <= (w_nstate == S_DONE);
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
      r_qph   <= w_nqph;
`endif
    end
  end

  assign bus.timer_load    = r_load;
  assign bus.timer_in      = r_in;
  assign bus.timer_enablen = r_enn;
  assign bus.timer_clr     = r_clr;
  assign bus.heater_on     = r_heat;
  assign bus.alarm         = r_alarm;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a load-pulse scoreboard.
// Runs with TICK_DIV=4, ALARM_CYCLES=5.
module tb_timer_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  timer_sequencer_if bus();

  timer_sequencer #(
    .TICK_DIV(4),
    .ALARM_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, score loads, drop strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.timer_load === 1'b1) begin
      if (exp_q.size() == 0) chk("load_spurious", bus.timer_load, 0);
      else chk("load_digit", bus.timer_in, exp_q.pop_front());
    end
    bus.key_valid = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
  endtask

  task automatic key(input logic [3:0] d, input bit expect_load);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    if (expect_load) exp_q.push_back(d);
    cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, bus.state, 0);
    chk({tag, "_load"}, bus.timer_load, 0);
    chk({tag, "_in"}, bus.timer_in, 0);
    chk({tag, "_enn"}, bus.timer_enablen, 1);
    chk({tag, "_clr"}, bus.timer_clr, 0);
    chk({tag, "_heat"}, bus.heater_on, 0);
    chk({tag, "_alarm"}, bus.alarm, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.door_closed = 1'b1;
    bus.timer_finished = 1'b0;
    cyc();
    cyc();
    chk_reset("rst");
    rst = 1'b0;

    // keys 1,3,0,0 back to back, then an ignored 5th
    key(4'd1, 1);
    chk("entry_state", bus.state, 1);
    key(4'd3, 1);
    key(4'd0, 1);
    key(4'd0, 1);
    chk("entry_state4", bus.state, 1);
    key(4'd7, 0);
    chk("fifth_noload", bus.timer_load, 0);

    // run with ticks every 4 cycles
    bus.start = 1'b1;
    cyc();
    chk("run_state", bus.state, 2);
    chk("run_heat", bus.heater_on, 1);
    chk("run_enn0", bus.timer_enablen, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("tick_k%0d", k), bus.timer_enablen, (k % 4 == 0) ? 0 : 1);
    end
    bus.timer_finished = 1'b1;
    cyc();
    bus.timer_finished = 1'b0;
    chk("done_state", bus.state, 4);
    chk("done_alarm", bus.alarm, 1);
    chk("done_heat", bus.heater_on, 0);
    chk("done_enn", bus.timer_enablen, 1);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.alarm === 1'b1) n++;
    end
    chk("alarm_len", n, 5);
    chk("alarm_idle", bus.state, 0);

    // door open at prescaler 2, resume holds phase
    bus.start = 1'b1;
    cyc();
    chk("run2_state", bus.state, 2);
    cyc();
    cyc();
    bus.door_closed = 1'b0;
    cyc();
    chk("door_pause", bus.state, 3);
    chk("pause_heat", bus.heater_on, 0);
    chk("pause_enn", bus.timer_enablen, 1);
    bus.door_closed = 1'b1;
    cyc();
    chk("pause_hold", bus.state, 3);
    bus.start = 1'b1;
    cyc();
    chk("resume_state", bus.state, 2);
    cyc();
    chk("resume_enn1", bus.timer_enablen, 1);
    cyc();
    chk("resume_tick", bus.timer_enablen, 0);

    // stop+start+key together in RUN -> PAUSE only
    bus.stop = 1'b1;
    bus.start = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd8;
    cyc();
    chk("multi_pause", bus.state, 3);
    chk("multi_noload", bus.timer_load, 0);
    bus.stop = 1'b1;
    cyc();
    chk("pstop_clr", bus.timer_clr, 1);
    chk("pstop_idle", bus.state, 0);
    cyc();
    chk("pstop_clr_end", bus.timer_clr, 0);

    // key acknowledges DONE without loading
    bus.start = 1'b1;
    cyc();
    bus.timer_finished = 1'b1;
    cyc();
    bus.timer_finished = 1'b0;
    chk("done2_state", bus.state, 4);
    key(4'd5, 0);
    chk("ack_idle", bus.state, 0);
    chk("ack_alarm", bus.alarm, 0);
    chk("ack_noload", bus.timer_load, 0);

    // out-of-range digit ignored, stop in ENTRY clears
    key(4'd12, 0);
    chk("badkey_idle", bus.state, 0);
    key(4'd9, 1);
    chk("entry2_state", bus.state, 1);
    bus.stop = 1'b1;
    cyc();
    chk("estop_clr", bus.timer_clr, 1);
    chk("estop_idle", bus.state, 0);

    // start with timer already at zero
    bus.timer_finished = 1'b1;
    bus.start = 1'b1;
`ifdef TIMER_SEQUENCER_QUICKSTART_EN
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd0);
    cyc();
    chk("qs_state1", bus.state, 5);
    cyc();
    bus.timer_finished = 1'b0;
    chk("qs_state2", bus.state, 5);
    cyc();
    chk("qs_run", bus.state, 2);
`else
    cyc();
    bus.timer_finished = 1'b0;
    chk("qs_ignored", bus.state, 0);
    bus.start = 1'b1;
    cyc();
    chk("qs_run", bus.state, 2);
`endif

    // reset in RUN wins over a same-cycle stop
    rst = 1'b1;
    bus.stop = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset("midrst");

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
